// File: rtl/spike_window_classifier.sv
// rtl/spike_window_classifier.sv - per-channel spike counting over a fixed window with serial argmax readout
// Counts run only in COUNT; SCAN walks one channel per cycle, then one extra cycle publishes the result.
module spike_window_classifier #(
  parameter int N_CH   = 8,
  parameter int CNT_W  = 8,
  parameter int WINDOW = 100,
  parameter int WIN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    boot_mode,
  input  logic [N_CH-1:0]         edge_spike,
  input  logic                    result_ready,
  output logic                    result_valid,
  output logic [N_CH*CNT_W-1:0]   counts_out,
  output logic [$clog2(N_CH)-1:0] winner,
  output logic                    tie,
  output logic                    no_spike,
  output logic                    saturated
);
  localparam int IDX_W = $clog2(N_CH);
  localparam int SCN_W = $clog2(N_CH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [WIN_W-1:0] LAST_TICK = WIN_W'(WINDOW - 1);
  localparam logic [SCN_W-1:0] SCAN_DONE = SCN_W'(N_CH);

  typedef enum logic [1:0] {COUNT, SCAN, HOLD} state_e;

  state_e                     state_q, state_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIN_W-1:0]           timer_q, timer_d;
  logic                       sat_q, sat_d;
  logic [SCN_W-1:0]           scan_q, scan_d;
  logic [CNT_W-1:0]           best_q, best_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       tie_acc_q, tie_acc_d;
  logic                       valid_q, valid_d;
  logic [N_CH*CNT_W-1:0]      counts_q, counts_d;
  logic [IDX_W-1:0]           winner_q, winner_d;
  logic                       tie_q, tie_d;
  logic                       no_spike_q, no_spike_d;
  logic                       saturated_q, saturated_d;
  logic [CNT_W-1:0]           scan_cnt;

  assign scan_cnt = cnt_q[scan_q[IDX_W-1:0]];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    sat_d       = sat_q;
    scan_d      = scan_q;
    best_d      = best_q;
    idx_d       = idx_q;
    tie_acc_d   = tie_acc_q;
    valid_d     = valid_q;
    counts_d    = counts_q;
    winner_d    = winner_q;
    tie_d       = tie_q;
    no_spike_d  = no_spike_q;
    saturated_d = saturated_q;
    if (!boot_mode) begin
      unique case (state_q)
        COUNT: begin
          for (int i = 0; i < N_CH; i++) begin
            if (edge_spike[i]) begin
              if (cnt_q[i] == CNT_MAX) sat_d = 1'b1;
              else                     cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          timer_d = timer_q + 1'b1;
          if (timer_q == LAST_TICK) begin
            state_d = SCAN;
            scan_d  = '0;
          end
        end
        SCAN: begin
          if (scan_q == SCAN_DONE) begin
            counts_d    = cnt_q;
            winner_d    = idx_q;
            tie_d       = tie_acc_q;
            no_spike_d  = (best_q == '0);
            saturated_d = sat_q;
            valid_d     = 1'b1;
            state_d     = HOLD;
          end else begin
            // strict '>' keeps the lowest index on equal counts
            if (scan_q == '0 || scan_cnt > best_q) begin
              best_d    = scan_cnt;
              idx_d     = scan_q[IDX_W-1:0];
              tie_acc_d = 1'b0;
            end else if (scan_cnt == best_q) begin
              tie_acc_d = 1'b1;
            end
            scan_d = scan_q + 1'b1;
          end
        end
        HOLD: begin
          if (result_ready) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            timer_d = '0;
            sat_d   = 1'b0;
            state_d = COUNT;
          end
        end
        default: state_d = COUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COUNT;
      cnt_q       <= '0;
      timer_q     <= '0;
      sat_q       <= 1'b0;
      scan_q      <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      tie_acc_q   <= 1'b0;
      valid_q     <= 1'b0;
      counts_q    <= '0;
      winner_q    <= '0;
      tie_q       <= 1'b0;
      no_spike_q  <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      sat_q       <= sat_d;
      scan_q      <= scan_d;
      best_q      <= best_d;
      idx_q       <= idx_d;
      tie_acc_q   <= tie_acc_d;
      valid_q     <= valid_d;
      counts_q    <= counts_d;
      winner_q    <= winner_d;
      tie_q       <= tie_d;
      no_spike_q  <= no_spike_d;
      saturated_q <= saturated_d;
    end
  end

  assign result_valid = valid_q;
  assign counts_out   = counts_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign no_spike     = no_spike_q;
  assign saturated    = saturated_q;
endmodule

// File: tb/tb_spike_window_classifier.sv
// tb/tb_spike_window_classifier.sv - bench for spike_window_classifier
// Three instances (WINDOW=10, CNT_W=4/WINDOW=20, WINDOW=1) share stimulus; sel picks the one under test.
module tb_spike_window_classifier;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       boot_mode = 1'b0;
  logic       result_ready = 1'b0;
  logic [7:0] edge_spike = '0;

  logic va, ta, na, sa, vb, tb, nb, sb, vc, tc, nc, sc;
  logic [63:0] ca, cc;
  logic [31:0] cb;
  logic [2:0]  wa, wb, wc;

  spike_window_classifier #(.N_CH(8), .CNT_W(8), .WINDOW(10), .WIN_W(16)) dut_a (
    .clk(clk), .rst(rst), .boot_mode(boot_mode), .edge_spike(edge_spike),
    .result_ready(result_ready), .result_valid(va), .counts_out(ca), .winner(wa),
    .tie(ta), .no_spike(na), .saturated(sa));
  spike_window_classifier #(.N_CH(8), .CNT_W(4), .WINDOW(20), .WIN_W(16)) dut_b (
    .clk(clk), .rst(rst), .boot_mode(boot_mode), .edge_spike(edge_spike),
    .result_ready(result_ready), .result_valid(vb), .counts_out(cb), .winner(wb),
    .tie(tb), .no_spike(nb), .saturated(sb));
  spike_window_classifier #(.N_CH(8), .CNT_W(8), .WINDOW(1), .WIN_W(16)) dut_c (
    .clk(clk), .rst(rst), .boot_mode(boot_mode), .edge_spike(edge_spike),
    .result_ready(result_ready), .result_valid(vc), .counts_out(cc), .winner(wc),
    .tie(tc), .no_spike(nc), .saturated(sc));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int raw [8];

  function automatic int win_len();
    return (sel == 0) ? 10 : (sel == 1) ? 20 : 1;
  endfunction
  function automatic int cmax();
    return (sel == 1) ? 15 : 255;
  endfunction
  function automatic logic [31:0] o_cnt(input int i);
    case (sel)
      0:       return 32'(ca[i*8 +: 8]);
      1:       return 32'(cb[i*4 +: 4]);
      default: return 32'(cc[i*8 +: 8]);
    endcase
  endfunction
  function automatic logic o_valid();
    return (sel == 0) ? va : (sel == 1) ? vb : vc;
  endfunction
  function automatic logic [2:0] o_winner();
    return (sel == 0) ? wa : (sel == 1) ? wb : wc;
  endfunction
  function automatic logic o_tie();
    return (sel == 0) ? ta : (sel == 1) ? tb : tc;
  endfunction
  function automatic logic o_nospike();
    return (sel == 0) ? na : (sel == 1) ? nb : nc;
  endfunction
  function automatic logic o_sat();
    return (sel == 0) ? sa : (sel == 1) ? sb : sc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_raw();
    for (int i = 0; i < 8; i++) raw[i] = 0;
  endtask

  // Reference: saturating sums, argmax with lowest index on ties
  task automatic check_result(input string tag, input logic exp_valid);
    int mx = 0, w = 0, nt = 0, c;
    logic s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = (raw[i] > cmax()) ? cmax() : raw[i];
      if (raw[i] > cmax()) s = 1'b1;
      check({tag, "_count"}, o_cnt(i), c);
      if (c > mx) begin mx = c; w = i; end
    end
    for (int i = 0; i < 8; i++) begin
      c = (raw[i] > cmax()) ? cmax() : raw[i];
      if (c == mx) nt++;
    end
    check({tag, "_valid"}, o_valid(), exp_valid);
    check({tag, "_winner"}, o_winner(), w);
    check({tag, "_tie"}, o_tie(), nt > 1);
    check({tag, "_no_spike"}, o_nospike(), mx == 0);
    check({tag, "_saturated"}, o_sat(), s);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 8; i++) check({tag, "_count"}, o_cnt(i), 0);
    check({tag, "_valid"}, o_valid(), 0);
    check({tag, "_winner"}, o_winner(), 0);
    check({tag, "_tie"}, o_tie(), 0);
    check({tag, "_no_spike"}, o_nospike(), 0);
    check({tag, "_saturated"}, o_sat(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; boot_mode = 1'b0; result_ready = 1'b0; edge_spike = '0;
    #1 check_zero("reset_async");
    @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    clear_raw();
  endtask

  // Drives one window of counted cycles; boot cycles are inserted at position boot_at and do not count
  task automatic count_window(input logic [7:0] ma, input int la, input logic [7:0] mb, input int lb,
                              input logic [7:0] rm, input int boot_at, input int boot_n);
    int n = 0;
    int bl = boot_n;
    while (n < win_len()) begin
      result_ready = 1'($urandom);
      if (n == boot_at && bl > 0) begin
        boot_mode  = 1'b1;
        edge_spike = 8'h10 | 8'($urandom);
        bl--;
      end else begin
        boot_mode  = 1'b0;
        edge_spike = ((n < la) ? ma : 8'h00) | ((n < lb) ? mb : 8'h00) | (rm & 8'($urandom));
        for (int i = 0; i < 8; i++) if (edge_spike[i]) raw[i]++;
        n++;
      end
      cycle();
    end
    boot_mode = 1'b0;
  endtask

  task automatic await_result(input string tag);
    int lat = 0;
    while (!o_valid() && lat < 40) begin
      edge_spike   = 8'($urandom);
      result_ready = 1'($urandom);
      cycle();
      lat++;
    end
    check({tag, "_latency"}, lat, 9);
    check_result(tag, 1'b1);
  endtask

  task automatic hold_accept(input int hold);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        result_ready = 1'b0;
        boot_mode    = 1'($urandom);
        edge_spike   = 8'h04 | 8'($urandom);
        cycle();
        check_result("hold", 1'b1);
      end
      boot_mode = 1'b1; result_ready = 1'b1;
      cycle();
      check("boot_blocks_handshake", o_valid(), 1);
    end
    boot_mode = 1'b0; result_ready = 1'b1; edge_spike = 8'($urandom);
    cycle();
    check_result("after_handshake", 1'b0);
    result_ready = 1'b0;
    clear_raw();
  endtask

  initial begin
    @(negedge clk);
    sel = 0;
    do_reset();

    count_window(8'h08, 4, 8'h20, 2, 8'h00, -1, 0);
    await_result("single_winner");
    hold_accept(0);

    count_window(8'h42, 3, 8'h00, 0, 8'h00, -1, 0);
    await_result("tie_1_6");
    hold_accept(0);

    count_window(8'h00, 0, 8'h00, 0, 8'h00, -1, 0);
    await_result("no_spike");
    hold_accept(0);

    count_window(8'h00, 0, 8'h00, 0, 8'hff, -1, 0);
    await_result("long_hold");
    hold_accept(30);

    count_window(8'h00, 0, 8'h00, 0, 8'h6b, 4, 5);
    await_result("boot_mid_window");
    hold_accept(1);

    for (int k = 0; k < 6; k++) begin
      count_window(8'h00, 0, 8'h00, 0, 8'($urandom), $urandom_range(0, 12), $urandom_range(0, 3));
      await_result("random");
      hold_accept($urandom_range(0, 3));
    end

    count_window(8'h00, 0, 8'h00, 0, 8'hff, -1, 0);
    cycle(); cycle(); cycle();
    rst = 1'b0;
    #1 check_zero("reset_mid_scan");
    @(negedge clk);
    rst = 1'b1;
    clear_raw();
    count_window(8'h00, 0, 8'h00, 0, 8'hff, -1, 0);
    await_result("after_scan_reset");
    hold_accept(0);

    sel = 1;
    do_reset();
    count_window(8'h01, 20, 8'h00, 0, 8'h00, -1, 0);
    await_result("saturate");
    hold_accept(0);
    count_window(8'h00, 0, 8'h00, 0, 8'hff, 7, 2);
    await_result("narrow_random");
    hold_accept(2);

    sel = 2;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      count_window(8'h00, 0, 8'h00, 0, 8'($urandom), 0, $urandom_range(0, 1));
      await_result("window_one");
      hold_accept($urandom_range(0, 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spike_window_classifier.md
Name: spike_window_classifier

Overview:
- Sits directly downstream of the input edge detector and consumes its one-cycle-per-edge spike vector.
- Counts rising-edge spikes per channel over a fixed window of clock cycles.
- After each window, serially scans the counts to find the most active channel (argmax).
- Presents per-channel counts, the winning channel, and tie/no-spike flags through a valid/ready handshake. The result feeds classification readout or learning logic.

Parameters:
- N_CH, 8, number of spike channels (matches the edge detector width).
- CNT_W, 8, width of each per-channel counter. Counters saturate.
- WINDOW, 100, number of active counting cycles per window. Legal range 1..2^WIN_W-1.
- WIN_W, 16, width of the window timer.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- boot_mode  in  1  when high, the whole block freezes: no counting, no timer advance, no scan step, no handshake completion.
- edge_spike  in  N_CH  one-cycle edge pulses from the edge detector. Bit i is channel i.
- result_ready  in  1  consumer accepts the result.
- result_valid  out  1  result registers are valid.
- counts_out  out  N_CH*CNT_W  snapshot of the window counts. Channel i occupies bits [i*CNT_W +: CNT_W].
- winner  out  $clog2(N_CH)  index of the channel with the highest count.
- tie  out  1  at least one other channel equals the winner's count.
- no_spike  out  1  all counts were zero in the window.
- saturated  out  1  at least one counter saturated in the window.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0.
  - Counters and timer are 0.
  - The FSM is in COUNT.
  - Reset mid-window or mid-scan discards all partial data.
- FSM states: COUNT, SCAN, HOLD.
- COUNT:
  - On each cycle with boot_mode=0, for every i with edge_spike[i]=1: cnt[i] <= cnt[i]+1.
  - Counters saturate at 2^CNT_W-1; a saturated increment sets the internal sat flag.
  - timer increments every cycle with boot_mode=0.
  - On the cycle when timer==WINDOW-1, that cycle's spikes are still counted. Next state is SCAN, and the scan index is cleared to 0.
- SCAN: one channel per cycle, index i = 0..N_CH-1, boot_mode=0 only.
  - i==0: best<=cnt[0], idx<=0, tie<=0.
  - i>0 and cnt[i] > best: best<=cnt[i], idx<=i, tie<=0.
  - i>0 and cnt[i] == best: tie<=1, idx unchanged (the lowest index wins ties).
  - After i==N_CH-1 is evaluated, the next cycle registers the outputs:
    - counts_out <= all cnt
    - winner <= final idx
    - tie <= final tie
    - no_spike <= (best==0)
    - saturated <= sat
    - result_valid <= 1
    - state <= HOLD
  - Latency from the last COUNT cycle to result_valid high is N_CH+1 cycles.
  - When no_spike=1, the outputs are winner=0 and tie=1 (for N_CH>1).
- HOLD:
  - result_valid stays 1 and all result outputs are stable until handshake.
  - Handshake = result_valid & result_ready & !boot_mode.
  - On the handshake cycle:
    - result_valid <= 0
    - cnt[], timer, and sat are cleared
    - state <= COUNT
  - The first counted cycle of the new window is the cycle after the handshake.
- Spikes arriving in SCAN or HOLD are ignored, not counted toward any window.
- result_ready asserted while result_valid=0 has no effect.
- The result output registers change only at SCAN completion and never while result_valid=1.
- boot_mode=1 holds every register. A spike in that cycle is dropped.
- WINDOW=1: every window is exactly one counting cycle.

Test Plan:
- Reset, then WINDOW=10. Pulse channel 3 on 4 cycles and channel 5 on 2 cycles; result_ready=1 → result_valid rises 9 cycles after window end, winner=3, tie=0, no_spike=0, counts_out ch3=4, ch5=2, other channels 0. Handshake completes the next cycle.
- Pulse channels 1 and 6 each 3 times in one window → winner=1, tie=1.
- No spikes in the window → winner=0, no_spike=1, tie=1.
- CNT_W=4, WINDOW=20, channel 0 pulsing every cycle → count 15, saturated=1, winner=0.
- Hold result_ready=0 for 30 cycles while pulsing channel 2 → outputs are stable, the pulses are not counted, and the next window starts with zeroed counts after ready rises.
- Assert boot_mode for 5 cycles mid-window with spikes on channel 4 → those spikes are dropped and the window end is delayed 5 cycles. Then assert rst=0 mid-scan → all outputs are 0 immediately, the FSM is in COUNT, and result_valid=0.
